disp_scan_mux: RTL and testbench



---
 rtl/disp_pkg.sv | 13 +
 rtl/scan_prescaler.sv | 26 ++
 rtl/disp_scan_mux.sv | 135 +++++++++++++
 tb/tb_disp_scan_mux.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
package disp_pkg;

  localparam int DIGITS_DEF = 8;
  localparam int NIB_W      = 4;
  localparam int MAX_DIGITS = 32;

  // Active-low one-hot anode pattern with digit idx enabled; callers size-cast to their width.
  function automatic logic [MAX_DIGITS-1:0] an_onehot(input int unsigned idx);
    an_onehot = ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one cycle out of every DIV (always high when DIV == 1).
module scan_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Double-buffered, prescaled scan of a packed digit word onto one-hot-low anodes.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DIV    = 100000
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic [NIB_W*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]       dp_mask,
  input  logic                    load,
  output logic [NIB_W-1:0]        digit,
  output logic                    dp,
  output logic                    blank,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST   = DIGITS'(an_onehot(0));

  logic                    tick;
  logic                    frame_wrap;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        n;
  logic                    pending;
  logic [NIB_W*DIGITS-1:0] staging_val;
  logic [DIGITS-1:0]       staging_dp;
  logic [NIB_W*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]       shadow_dp;
  logic [NIB_W*DIGITS-1:0] shadow_val_nx;
  logic [DIGITS-1:0]       shadow_dp_nx;
  logic [NIB_W-1:0]        digit_nx;
  logic                    dp_nx;
  logic                    blank_nx;
  logic [DIGITS-1:0]       an_nx;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  assign frame_wrap = tick && (idx == IDX_LAST);
  assign n          = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= n;
    end
  end

  // A load on the wrap cycle bypasses staging so it shows in the very next frame.
  always_comb begin
    shadow_val_nx = shadow_val;
    shadow_dp_nx  = shadow_dp;
    if (frame_wrap) begin
      if (load) begin
        shadow_val_nx = value;
        shadow_dp_nx  = dp_mask;
      end else if (pending) begin
        shadow_val_nx = staging_val;
        shadow_dp_nx  = staging_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      staging_val <= '0;
      staging_dp  <= '0;
      pending     <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
    end else begin
      if (load) begin
        staging_val <= value;
        staging_dp  <= dp_mask;
        pending     <= !frame_wrap;
      end else if (frame_wrap) begin
        pending     <= 1'b0;
      end
      shadow_val <= shadow_val_nx;
      shadow_dp  <= shadow_dp_nx;
    end
  end

  assign digit_nx = shadow_val_nx[{n, 2'b00} +: NIB_W];
  assign dp_nx    = shadow_dp_nx[n];
  assign an_nx    = DIGITS'(an_onehot(32'(n)));

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[i]: every nibble at position i and above is zero.
  logic [DIGITS-1:0] zero_from;

  always_comb begin
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i == DIGITS - 1) begin
        zero_from[i] = (shadow_val_nx[NIB_W*i +: NIB_W] == '0);
      end else begin
        zero_from[i] = (shadow_val_nx[NIB_W*i +: NIB_W] == '0) && zero_from[i+1];
      end
    end
  end

  assign blank_nx = (n != '0) && !shadow_dp_nx[n] && zero_from[n];
`else
  assign blank_nx = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      an         <= AN_RST;
      digit      <= '0;
      dp         <= 1'b0;
      blank      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (tick) begin
        an    <= an_nx;
        digit <= digit_nx;
        dp    <= dp_nx;
        blank <= blank_nx;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux (DIGITS=8, DIV=4): frame-level expected queue, per-cycle output checks.
module tb_disp_scan_mux;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;
  localparam int W      = 14;  // {an[7:0], digit[3:0], dp, blank}

  logic                  clk;
  logic                  sys_rst_n;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic                  load;
  logic [3:0]            digit;
  logic                  dp;
  logic                  blank;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  disp_scan_mux #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .value      (value),
    .dp_mask    (dp_mask),
    .load       (load),
    .digit      (digit),
    .dp         (dp),
    .blank      (blank),
    .an         (an),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0]        exp_q[$];
  logic [W-1:0]        cur_exp;
  int                  n_checks;
  int                  n_pass;
  int                  e;          // clock edges since reset release
  logic [4*DIGITS-1:0] m_stage_val;
  logic [DIGITS-1:0]   m_stage_dp;
  logic                m_pending;
  logic [4*DIGITS-1:0] m_shadow_val;
  logic [DIGITS-1:0]   m_shadow_dp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic exp_blank(input logic [31:0] v, input logic [7:0] m, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    logic [31:0] vv;
    vv = v;
    if (k == 0 || m[k]) return 1'b0;
    for (int j = k; j < DIGITS; j++) begin
      if (vv[4*j +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected output for each of the next DIGITS slots, fixed at the start of the frame.
  task automatic push_frame(input logic [31:0] v, input logic [7:0] m);
    logic [7:0] a;
    logic [31:0] vv;
    vv = v;
    for (int k = 0; k < DIGITS; k++) begin
      a = ~(8'h01 << k);
      exp_q.push_back({a, vv[4*k +: 4], m[k], exp_blank(v, m, k)});
    end
  endtask

  task automatic pop_slot();
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
    end else begin
      cur_exp = exp_q.pop_front();
    end
  endtask

  task automatic check_outputs(input logic exp_fd);
    check("an",         32'(an),         32'(cur_exp[13:6]));
    check("digit",      32'(digit),      32'(cur_exp[5:2]));
    check("dp",         32'(dp),         32'(cur_exp[1]));
    check("blank",      32'(blank),      32'(cur_exp[0]));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic model_reset();
    e            = 0;
    m_stage_val  = '0;
    m_stage_dp   = '0;
    m_pending    = 1'b0;
    m_shadow_val = '0;
    m_shadow_dp  = '0;
    exp_q.delete();
    push_frame(m_shadow_val, m_shadow_dp);
    pop_slot();
  endtask

  // driver: one clock edge, model update, output checks
  task automatic step();
    logic        l_now;
    logic [31:0] l_val;
    logic [7:0]  l_dp;
    logic        wrap;
    l_now = load;
    l_val = value;
    l_dp  = dp_mask;
    @(posedge clk);
    #1;
    e++;
    wrap = (e % FRAME == 0);
    if (l_now) begin
      m_stage_val = l_val;
      m_stage_dp  = l_dp;
      if (wrap) begin
        m_shadow_val = l_val;
        m_shadow_dp  = l_dp;
        m_pending    = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (wrap && m_pending) begin
      m_shadow_val = m_stage_val;
      m_shadow_dp  = m_stage_dp;
      m_pending    = 1'b0;
    end
    if (wrap) push_frame(m_shadow_val, m_shadow_dp);
    if (e % DIV == 0) pop_slot();
    check_outputs(wrap);
  endtask

  task automatic run_until(input int target);
    for (int k = 0; k < 1000 && e < target; k++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] m);
    value   = v;
    dp_mask = m;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    check_outputs(1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sys_rst_n = 1'b0;
    value     = '0;
    dp_mask   = '0;
    load      = 1'b0;
    e         = 0;
    cur_exp   = '0;
    repeat (3) @(posedge clk);
    release_reset();

    // idle frame after reset: first anode step at edge 4, frame_done at edge 32
    run_until(FRAME);

    // mid-frame load shows only from the next frame
    run_until(40);
    do_load(32'h1234_5678, 8'h00);
    run_until(3 * FRAME);

    // two loads in one frame: last wins
    run_until(100);
    do_load(32'hAAAA_AAAA, 8'hFF);
    run_until(110);
    do_load(32'h0000_00C3, 8'h01);
    run_until(5 * FRAME);

    // load exactly on the wrap edge: visible in the frame that starts there
    run_until(6 * FRAME - 1);
    do_load(32'h8765_4321, 8'h08);
    run_until(200);

    // leading-zero pattern with a decimal point on digit 3
    do_load(32'h0000_0405, 8'h08);
    run_until(8 * FRAME);

    // reset mid-frame (slot index 5) with a pending load
    run_until(260);
    do_load(32'hFFFF_0000, 8'hF0);
    run_until(8 * FRAME + 5 * DIV + 1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_an",         32'(an),         32'h0000_00FE);
    check("rst_digit",      32'(digit),      32'h0);
    check("rst_dp",         32'(dp),         32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    release_reset();
    run_until(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
